// File: rtl/rect_fill_engine_pkg.sv
// rtl/rect_fill_engine_pkg.sv - shared widths, mode and state encodings for the rect fill engine
`ifndef SCR_WIDTH_BITS
`define SCR_WIDTH_BITS 8
`endif
`ifndef SCR_HEIGHT_BITS
`define SCR_HEIGHT_BITS 7
`endif
`ifndef COLOR_SIZE
`define COLOR_SIZE 3
`endif

package rect_fill_engine_pkg;
    localparam int RF_X_BITS     = `SCR_WIDTH_BITS;
    localparam int RF_Y_BITS     = `SCR_HEIGHT_BITS;
    localparam int RF_COLOR_BITS = `COLOR_SIZE;
    localparam int RF_WR_HOLD    = 3;

    typedef enum logic [1:0] {
        RF_MODE_FILL    = 2'd0,
        RF_MODE_OUTLINE = 2'd1,
        RF_MODE_CIRCLE  = 2'd2,
        RF_MODE_RSVD    = 2'd3
    } rf_mode_e;

    typedef enum logic [2:0] {
        RF_IDLE   = 3'd0,
        RF_LOAD   = 3'd1,
        RF_STROBE = 3'd2,
        RF_GAP    = 3'd3,
        RF_NEXT   = 3'd4
    } rf_state_e;
endpackage

// File: rtl/rect_fill_engine_if.sv
// rtl/rect_fill_engine_if.sv - request handshake and frame-buffer write port of the rect fill engine
interface rect_fill_engine_if
    import rect_fill_engine_pkg::*;
#(
    parameter int X_BITS     = RF_X_BITS,
    parameter int Y_BITS     = RF_Y_BITS,
    parameter int COLOR_BITS = RF_COLOR_BITS
);
    logic                  start;
    logic [1:0]            mode;
    logic [X_BITS-1:0]     x_start;
    logic [X_BITS-1:0]     x_end;
    logic [Y_BITS-1:0]     y_start;
    logic [Y_BITS-1:0]     y_end;
    logic [COLOR_BITS-1:0] color;
    logic                  busy;
    logic                  done;
    logic [X_BITS-1:0]     paint_x_co;
    logic [Y_BITS-1:0]     paint_y_co;
    logic [COLOR_BITS-1:0] color_output;
    logic                  print_enable;

    modport master (
        output start, mode, x_start, x_end, y_start, y_end, color,
        input  busy, done, paint_x_co, paint_y_co, color_output, print_enable
    );

    modport slave (
        input  start, mode, x_start, x_end, y_start, y_end, color,
        output busy, done, paint_x_co, paint_y_co, color_output, print_enable
    );
endinterface

// File: rtl/rect_fill_mask.sv
// rtl/rect_fill_mask.sv - per-pixel write mask for FILL/OUTLINE/CIRCLE (circle under RECT_FILL_CIRCLE_EN)
module rect_fill_mask
    import rect_fill_engine_pkg::*;
#(
    parameter int X_BITS = RF_X_BITS,
    parameter int Y_BITS = RF_Y_BITS
) (
    input  logic [X_BITS-1:0] x,
    input  logic [Y_BITS-1:0] y,
    input  logic [X_BITS-1:0] x_start,
    input  logic [X_BITS-1:0] x_end,
    input  logic [Y_BITS-1:0] y_start,
    input  logic [Y_BITS-1:0] y_end,
    input  logic [1:0]        mode,
    output logic              write_pixel
);
    localparam logic [X_BITS-1:0] X_ONE = X_BITS'(1);
    localparam logic [Y_BITS-1:0] Y_ONE = Y_BITS'(1);

    logic edge_hit;
    logic circle_hit;

    assign edge_hit = (x == x_start) || (x == x_end - X_ONE) ||
                      (y == y_start) || (y == y_end - Y_ONE);

`ifdef RECT_FILL_CIRCLE_EN
    localparam int W = ((X_BITS > Y_BITS) ? X_BITS : Y_BITS) + 2;

    // Doubled offsets from the centre keep even-sized regions on an integer grid.
    logic signed [W-1:0]   dx, dy;
    logic signed [2*W-1:0] dx_ext, dy_ext, dx_sq, dy_sq;
    logic [W-1:0]          span_x, span_y, r;
    logic [2*W-1:0]        r_sq, dist_sq;

    assign dx      = $signed(W'({x, 1'b0}) - W'(x_start) - W'(x_end) + W'(1));
    assign dy      = $signed(W'({y, 1'b0}) - W'(y_start) - W'(y_end) + W'(1));
    assign dx_ext  = {{W{dx[W-1]}}, dx};
    assign dy_ext  = {{W{dy[W-1]}}, dy};
    assign dx_sq   = dx_ext * dx_ext;
    assign dy_sq   = dy_ext * dy_ext;
    assign dist_sq = $unsigned(dx_sq) + $unsigned(dy_sq);
    assign span_x  = W'(x_end) - W'(x_start);
    assign span_y  = W'(y_end) - W'(y_start);
    assign r       = (span_x < span_y) ? span_x : span_y;
    assign r_sq    = {{W{1'b0}}, r} * {{W{1'b0}}, r};
    assign circle_hit = (dist_sq <= r_sq);
`else
    assign circle_hit = 1'b1;
`endif

    always_comb begin
        write_pixel = 1'b1;
        case (rf_mode_e'(mode))
            RF_MODE_OUTLINE: write_pixel = edge_hit;
            RF_MODE_CIRCLE:  write_pixel = circle_hit;
            default:         write_pixel = 1'b1;
        endcase
    end
endmodule

// File: rtl/rect_fill_engine.sv
// rtl/rect_fill_engine.sv - raster pixel writer with start/busy/done handshake; circle mode via RECT_FILL_CIRCLE_EN
module rect_fill_engine
    import rect_fill_engine_pkg::*;
#(
    parameter int X_BITS     = RF_X_BITS,
    parameter int Y_BITS     = RF_Y_BITS,
    parameter int COLOR_BITS = RF_COLOR_BITS,
    parameter int WR_HOLD    = RF_WR_HOLD
) (
    input  logic               Clck,
    input  logic               Reset,
    rect_fill_engine_if.slave  bus
);
    localparam logic [X_BITS-1:0] X_ONE     = X_BITS'(1);
    localparam logic [Y_BITS-1:0] Y_ONE     = Y_BITS'(1);
    localparam logic [3:0]        HOLD_LAST = 4'(WR_HOLD - 1);

    rf_state_e         state;
    logic [3:0]        hold_cnt;
    logic [1:0]        mode_q;
    logic [X_BITS-1:0] xs_q, xe_q;
    logic [Y_BITS-1:0] ys_q, ye_q;
    logic              write_pixel;
    logic              last_x, last_y;

    // The paint coordinates double as the raster counters.
    assign last_x = (bus.paint_x_co == xe_q - X_ONE);
    assign last_y = (bus.paint_y_co == ye_q - Y_ONE);

    rect_fill_mask #(
        .X_BITS (X_BITS),
        .Y_BITS (Y_BITS)
    ) u_mask (
        .x           (bus.paint_x_co),
        .y           (bus.paint_y_co),
        .x_start     (xs_q),
        .x_end       (xe_q),
        .y_start     (ys_q),
        .y_end       (ye_q),
        .mode        (mode_q),
        .write_pixel (write_pixel)
    );

    always_ff @(posedge Clck) begin
        if (!Reset) begin
            state            <= RF_IDLE;
            hold_cnt         <= 4'd0;
            mode_q           <= RF_MODE_FILL;
            xs_q             <= '0;
            xe_q             <= '0;
            ys_q             <= '0;
            ye_q             <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.print_enable <= 1'b0;
            bus.paint_x_co   <= '0;
            bus.paint_y_co   <= '0;
            bus.color_output <= {COLOR_BITS{1'b0}};
        end else begin
            bus.done <= 1'b0;
            case (state)
                RF_IDLE: begin
                    if (bus.start) begin
                        mode_q           <= bus.mode;
                        xs_q             <= bus.x_start;
                        xe_q             <= bus.x_end;
                        ys_q             <= bus.y_start;
                        ye_q             <= bus.y_end;
                        bus.color_output <= bus.color;
                        if ((bus.x_end <= bus.x_start) || (bus.y_end <= bus.y_start)) begin
                            bus.done <= 1'b1;
                        end else begin
                            state          <= RF_LOAD;
                            bus.busy       <= 1'b1;
                            bus.paint_x_co <= bus.x_start;
                            bus.paint_y_co <= bus.y_start;
                        end
                    end
                end
                RF_LOAD: begin
                    if (write_pixel) begin
                        state            <= RF_STROBE;
                        bus.print_enable <= 1'b1;
                        hold_cnt         <= 4'd0;
                    end else begin
                        state <= RF_NEXT;
                    end
                end
                RF_STROBE: begin
                    if (hold_cnt == HOLD_LAST) begin
                        bus.print_enable <= 1'b0;
                        state            <= RF_GAP;
                    end else begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end
                RF_GAP: state <= RF_NEXT;
                RF_NEXT: begin
                    if (!last_x) begin
                        bus.paint_x_co <= bus.paint_x_co + X_ONE;
                        state          <= RF_LOAD;
                    end else if (!last_y) begin
                        bus.paint_x_co <= xs_q;
                        bus.paint_y_co <= bus.paint_y_co + Y_ONE;
                        state          <= RF_LOAD;
                    end else begin
                        state    <= RF_IDLE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end
                end
                default: state <= RF_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rect_fill_engine.sv
// tb/tb_rect_fill_engine.sv - scoreboard bench for rect_fill_engine
module tb_rect_fill_engine;
    import rect_fill_engine_pkg::*;

    localparam int XB   = 8;
    localparam int YB   = 7;
    localparam int CB   = 3;
    localparam int HOLD = 3;

    typedef struct {
        int x;
        int y;
        int c;
    } px_t;

    logic Clck  = 1'b0;
    logic Reset = 1'b0;

    px_t exp_q[$];
    int  n_checks   = 0;
    int  n_fail     = 0;
    int  strobes    = 0;
    int  done_count = 0;
    int  cyc        = 0;
    int  accept_cyc = 0;
    bit  abort      = 1'b0;

    always #5 Clck = ~Clck;
    always @(posedge Clck) cyc <= cyc + 1;

    rect_fill_engine_if #(.X_BITS(XB), .Y_BITS(YB), .COLOR_BITS(CB)) bus ();

    rect_fill_engine #(
        .X_BITS     (XB),
        .Y_BITS     (YB),
        .COLOR_BITS (CB),
        .WR_HOLD    (HOLD)
    ) dut (
        .Clck  (Clck),
        .Reset (Reset),
        .bus   (bus)
    );

    function automatic bit would_write(input int m, input int xs, input int xe,
                                       input int ys, input int ye, input int x, input int y);
        int dx, dy, r;
        case (m)
            1: return (x == xs) || (x == xe - 1) || (y == ys) || (y == ye - 1);
            2: begin
`ifdef RECT_FILL_CIRCLE_EN
                dx = 2 * x - (xs + xe - 1);
                dy = 2 * y - (ys + ye - 1);
                r  = ((xe - xs) < (ye - ys)) ? (xe - xs) : (ye - ys);
                return (dx * dx + dy * dy) <= (r * r);
`else
                dx = 0; dy = 0; r = 0;
                return 1'b1;
`endif
            end
            default: return 1'b1;
        endcase
    endfunction

    task automatic monitor();
        px_t e;
        bit  prev = 1'b0;
        int  w = 0, hx = 0, hy = 0;
        forever begin
            @(negedge Clck);
            if (bus.done === 1'b1) done_count++;
            if (bus.print_enable === 1'b1) begin
                if (!prev) begin
                    strobes++;
                    w  = 1;
                    hx = int'(bus.paint_x_co);
                    hy = int'(bus.paint_y_co);
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_strobe: got (%0d,%0d) required no write", hx, hy);
                    end else begin
                        e = exp_q.pop_front();
                        if (hx !== e.x || hy !== e.y || int'(bus.color_output) !== e.c) begin
                            n_fail++;
                            $display("FAIL pixel: got (%0d,%0d,c%0d) required (%0d,%0d,c%0d)",
                                     hx, hy, bus.color_output, e.x, e.y, e.c);
                        end
                    end
                end else begin
                    w++;
                    n_checks++;
                    if (int'(bus.paint_x_co) !== hx || int'(bus.paint_y_co) !== hy) begin
                        n_fail++;
                        $display("FAIL coord_stable: got (%0d,%0d) required (%0d,%0d)",
                                 bus.paint_x_co, bus.paint_y_co, hx, hy);
                    end
                end
            end else if (prev && !abort) begin
                n_checks++;
                if (w !== HOLD) begin
                    n_fail++;
                    $display("FAIL strobe_width: got %0d required %0d", w, HOLD);
                end
            end
            prev = (bus.print_enable === 1'b1);
        end
    endtask

    task automatic start_op(input int m, input int xs, input int xe, input int ys,
                            input int ye, input int col, output int exp_cycles);
        px_t p;
        exp_cycles = 0;
        for (int y = ys; y < ye; y++) begin
            for (int x = xs; x < xe; x++) begin
                if (would_write(m, xs, xe, ys, ye, x, y)) begin
                    p.x = x; p.y = y; p.c = col;
                    exp_q.push_back(p);
                    exp_cycles += HOLD + 3;
                end else begin
                    exp_cycles += 2;
                end
            end
        end
        @(negedge Clck);
        bus.start   = 1'b1;
        bus.mode    = 2'(m);
        bus.x_start = XB'(xs);
        bus.x_end   = XB'(xe);
        bus.y_start = YB'(ys);
        bus.y_end   = YB'(ye);
        bus.color   = CB'(col);
        @(posedge Clck);
        #1;
        accept_cyc  = cyc;
        bus.start   = 1'b0;
        bus.mode    = 2'($urandom_range(0, 3));
        bus.x_start = XB'($urandom_range(0, 255));
        bus.x_end   = XB'($urandom_range(0, 255));
        bus.y_start = YB'($urandom_range(0, 127));
        bus.y_end   = YB'($urandom_range(0, 127));
        bus.color   = CB'($urandom_range(0, 7));
    endtask

    task automatic wait_done(input int exp_cycles, input bit pulse_check, input string name);
        int guard = 0;
        while (bus.done !== 1'b1 && guard < exp_cycles + 100) begin
            @(posedge Clck);
            #1;
            guard++;
        end
        n_checks++;
        if (bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_done_timeout: got done=%b required 1", name, bus.done);
        end
        n_checks++;
        if (cyc - accept_cyc !== exp_cycles) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d required %0d", name, cyc - accept_cyc, exp_cycles);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_busy_at_done: got %b required 0", name, bus.busy);
        end
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL %s_missing_strobes: got %0d pending required 0", name, exp_q.size());
        end
        if (pulse_check) begin
            @(posedge Clck);
            #1;
            n_checks++;
            if (bus.done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_done_pulse: got %b required 0", name, bus.done);
            end
        end
    endtask

    task automatic check_busy(input logic want, input string name);
        n_checks++;
        if (bus.busy !== want) begin
            n_fail++;
            $display("FAIL %s_busy: got %b required %b", name, bus.busy, want);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b1;
        bus.mode = 2'd0; bus.x_start = 8'd1; bus.x_end = 8'd4;
        bus.y_start = 7'd1; bus.y_end = 7'd3; bus.color = 3'd5;
        repeat (3) @(posedge Clck);
        #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b required 0", bus.done); end
        n_checks++; if (bus.print_enable !== 1'b0) begin n_fail++; $display("FAIL reset_pe: got %b required 0", bus.print_enable); end
        n_checks++; if (bus.paint_x_co !== 8'd0) begin n_fail++; $display("FAIL reset_x: got %0d required 0", bus.paint_x_co); end
        n_checks++; if (bus.paint_y_co !== 7'd0) begin n_fail++; $display("FAIL reset_y: got %0d required 0", bus.paint_y_co); end
        n_checks++; if (bus.color_output !== 3'd0) begin n_fail++; $display("FAIL reset_color: got %0d required 0", bus.color_output); end
        bus.start = 1'b0;
        @(negedge Clck);
        Reset = 1'b1;
        repeat (2) @(posedge Clck);
    endtask

    task automatic test_fill();
        int ec;
        start_op(0, 10, 13, 20, 22, 2, ec);
        check_busy(1'b1, "fill");
        wait_done(36, 1'b1, "fill");
    endtask

    task automatic test_outline();
        int ec, s0;
        s0 = strobes;
        start_op(1, 0, 4, 0, 4, 6, ec);
        check_busy(1'b1, "outline");
        wait_done(80, 1'b1, "outline");
        n_checks++;
        if (strobes - s0 !== 12) begin
            n_fail++;
            $display("FAIL outline_count: got %0d required 12", strobes - s0);
        end
    endtask

    task automatic test_empty();
        int ec;
        start_op(0, 5, 5, 2, 9, 1, ec);
        check_busy(1'b0, "empty_x");
        wait_done(0, 1'b1, "empty_x");
        start_op(0, 3, 9, 6, 4, 4, ec);
        check_busy(1'b0, "empty_y");
        wait_done(0, 1'b1, "empty_y");
    endtask

    task automatic test_ignore_start();
        int ec;
        start_op(0, 10, 14, 20, 23, 5, ec);
        @(posedge Clck);
        @(negedge Clck);
        bus.start = 1'b1; bus.mode = 2'd1;
        bus.x_start = 8'd40; bus.x_end = 8'd42;
        bus.y_start = 7'd1; bus.y_end = 7'd2; bus.color = 3'd1;
        @(posedge Clck);
        #1;
        bus.start = 1'b0;
        wait_done(72, 1'b1, "ignore_start");
    endtask

    task automatic test_back_to_back();
        int ec;
        start_op(0, 1, 3, 1, 2, 7, ec);
        wait_done(12, 1'b0, "b2b_first");
        start_op(3, 2, 5, 2, 4, 3, ec);
        check_busy(1'b1, "b2b_second");
        wait_done(36, 1'b1, "b2b_second");
    endtask

    task automatic test_reset_mid();
        int ec, s0, d0, guard;
        s0 = strobes;
        guard = 0;
        start_op(0, 0, 8, 0, 8, 1, ec);
        while (strobes < s0 + 2 && guard < 200) begin
            @(negedge Clck);
            #1;
            guard++;
        end
        n_checks++;
        if (strobes < s0 + 2) begin
            n_fail++;
            $display("FAIL reset_mid_wait: got %0d strobes required 2", strobes - s0);
        end
        abort = 1'b1;
        d0 = done_count;
        Reset = 1'b0;
        @(posedge Clck);
        #1;
        n_checks++; if (bus.print_enable !== 1'b0) begin n_fail++; $display("FAIL reset_mid_pe: got %b required 0", bus.print_enable); end
        check_busy(1'b0, "reset_mid");
        repeat (2) @(posedge Clck);
        exp_q.delete();
        @(negedge Clck);
        Reset = 1'b1;
        repeat (5) @(posedge Clck);
        #1;
        n_checks++;
        if (done_count !== d0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: got %0d pulses required 0", done_count - d0);
        end
        abort = 1'b0;
        start_op(0, 3, 5, 3, 5, 6, ec);
        check_busy(1'b1, "after_reset");
        wait_done(24, 1'b1, "after_reset");
    endtask

    task automatic test_circle();
        int ec, s0;
        s0 = strobes;
`ifdef RECT_FILL_CIRCLE_EN
        start_op(2, 0, 7, 0, 7, 5, ec);
        wait_done(37 * (HOLD + 3) + 12 * 2, 1'b1, "circle");
        n_checks++;
        if (strobes - s0 !== 37) begin
            n_fail++;
            $display("FAIL circle_count: got %0d required 37", strobes - s0);
        end
`else
        start_op(2, 4, 6, 4, 6, 2, ec);
        wait_done(24, 1'b1, "mode2_fill");
        n_checks++;
        if (strobes - s0 !== 4) begin
            n_fail++;
            $display("FAIL mode2_fill_count: got %0d required 4", strobes - s0);
        end
`endif
    endtask

    initial begin
        bus.start = 1'b0; bus.mode = 2'd0;
        bus.x_start = '0; bus.x_end = '0;
        bus.y_start = '0; bus.y_end = '0; bus.color = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_fill();
        test_outline();
        test_empty();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_circle();
        repeat (3) @(posedge Clck);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
